// File: rtl/led_pattern_sequencer_if.sv
// Pattern RAM read port: enable and word address out, read data back.
// Data returns one cycle after an enabled edge; no handshake beyond en.
// The RAM cannot stall, so the port has no ready signal.
interface led_pattern_sequencer_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 4
);
  logic              en;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data;

  modport master (output en, output addr, input data);
  modport slave  (input en, input addr, output data);
endinterface

// File: rtl/led_pattern_sequencer.sv
// Steps a read pointer through [lo..hi] and shows each fetched pattern word on the LEDs.
// Latency: LEDs update two edges after the edge that enters READ; step period is PRESCALE+2 cycles.
// No backpressure: the RAM answers in fixed time; run=0 stops the sequence after the current read.
module led_pattern_sequencer #(
  parameter int ADDR_W   = 12,
  parameter int DATA_W   = 4,
  parameter int PRESCALE = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       run_i,
  input  logic                       dir_i,
  input  logic [ADDR_W-1:0]          base_addr_i,
  input  logic [ADDR_W-1:0]          last_addr_i,
  led_pattern_sequencer_if.master    rom,
  output logic [DATA_W-1:0]          leds_o,
  output logic                       wrap_o,
  output logic                       busy_o
);

  localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);

  typedef enum logic [1:0] {IDLE, READ, CAPTURE, COUNT} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   lo_q, lo_d;
  logic [ADDR_W-1:0]   hi_q, hi_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   leds_q, leds_d;
  logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d;
  logic                rom_en_q, rom_en_d;
  logic                wrap_q, wrap_d;
  logic                busy_q, busy_d;

  // State and output registers; reset clears every output immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      lo_q       <= '0;
      hi_q       <= '0;
      ptr_q      <= '0;
      cnt_q      <= '0;
      leds_q     <= '0;
      rom_addr_q <= '0;
      rom_en_q   <= 1'b0;
      wrap_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      lo_q       <= lo_d;
      hi_q       <= hi_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      leds_q     <= leds_d;
      rom_addr_q <= rom_addr_d;
      rom_en_q   <= rom_en_d;
      wrap_q     <= wrap_d;
      busy_q     <= busy_d;
    end
  end

  // Next-state logic; outputs are decoded from the next state so they line up with it.
  always_comb begin
    state_d = state_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    leds_d  = leds_q;
    wrap_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (run_i) begin
          lo_d = base_addr_i;
          hi_d = last_addr_i;
          // An empty or inverted window pins the pointer at lo in both directions.
          ptr_d   = (!dir_i || (last_addr_i <= base_addr_i)) ? base_addr_i : last_addr_i;
          state_d = READ;
        end
      end
      READ: state_d = CAPTURE;
      CAPTURE: begin
        leds_d  = rom.data;
        cnt_d   = '0;
        state_d = COUNT;
      end
      COUNT: begin
        if (!run_i) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = READ;
          // Wrap comes from the window compare, never from address overflow.
          if (hi_q <= lo_q) begin
            ptr_d  = lo_q;
            wrap_d = 1'b1;
          end else if (!dir_i) begin
            if (ptr_q == hi_q) begin
              ptr_d  = lo_q;
              wrap_d = 1'b1;
            end else begin
              ptr_d = ptr_q + ADDR_W'(1);
            end
          end else begin
            if (ptr_q == lo_q) begin
              ptr_d  = hi_q;
              wrap_d = 1'b1;
            end else begin
              ptr_d = ptr_q - ADDR_W'(1);
            end
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    rom_en_d   = (state_d == READ);
    rom_addr_d = (state_d == READ) ? ptr_d : rom_addr_q;
    busy_d     = (state_d != IDLE);
  end

  assign rom.en   = rom_en_q;
  assign rom.addr = rom_addr_q;
  assign leds_o   = leds_q;
  assign wrap_o   = wrap_q;
  assign busy_o   = busy_q;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Randomized scoreboard bench for led_pattern_sequencer with a behavioural RAM model.
// Stimulus pushes the expected read sequence; a monitor pops it on every RAM read.
// Each cycle the monitor also checks wrap, LED hold/update timing and stray reads.
module tb_led_pattern_sequencer;

  localparam int ADDR_W   = 12;
  localparam int DATA_W   = 4;
  localparam int PRESCALE = 4;
  localparam int PERIOD   = PRESCALE + 2;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic              wrap;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              run;
  logic              dir;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W-1:0] last_addr;
  logic [DATA_W-1:0] leds;
  logic              wrap;
  logic              busy;

  int vectors     = 0;
  int miscompares = 0;
  exp_t sb_q[$];

  led_pattern_sequencer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) rom_if ();

  led_pattern_sequencer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .PRESCALE(PRESCALE)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .run_i      (run),
    .dir_i      (dir),
    .base_addr_i(base_addr),
    .last_addr_i(last_addr),
    .rom        (rom_if),
    .leds_o     (leds),
    .wrap_o     (wrap),
    .busy_o     (busy)
  );

  always #5 clk = ~clk;

  // Pattern RAM: returns the low address nibble one cycle after an enabled edge, else 0.
  always @(posedge clk) begin
    rom_if.data <= rom_if.en ? rom_if.addr[DATA_W-1:0] : '0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_event(input string name, input int act, input int exp);
    vectors++;
    miscompares++;
    $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Reference sequence: list the addresses the window rules visit for k_n steps.
  task automatic plan(input int base, input int last, input bit d0, input int k_n, input int flip_at);
    int lo, hi, p, np;
    bit d, w, degen;
    exp_t e;
    lo = base; hi = last; d = d0; w = 1'b0;
    degen = (hi <= lo);
    p = (degen || !d) ? lo : hi;
    for (int k = 0; k < k_n; k++) begin
      e.addr = p[ADDR_W-1:0];
      e.wrap = w;
      sb_q.push_back(e);
      if (k == flip_at) d = ~d;
      w = 1'b0;
      if (degen)            begin np = lo; w = 1'b1; end
      else if (!d && p == hi) begin np = lo; w = 1'b1; end
      else if (!d)          np = p + 1;
      else if (p == lo)     begin np = hi; w = 1'b1; end
      else                  np = p - 1;
      p = np;
    end
  endtask

  // One run burst of exactly k_n reads: run drops during the last READ cycle.
  task automatic run_segment(input int base, input int last, input bit d0, input int k_n,
                             input int flip_at, input bit rel_rst);
    int  t;
    bit  got;
    plan(base, last, d0, k_n, flip_at);
    @(negedge clk);
    base_addr = base[ADDR_W-1:0];
    last_addr = last[ADDR_W-1:0];
    dir       = d0;
    run       = 1'b1;
    if (rel_rst) rst_n = 1'b1;
    for (int k = 0; k < k_n; k++) begin
      t = 0; got = 1'b0;
      for (int c = 0; c < 40; c++) begin
        @(negedge clk);
        t++;
        if (rom_if.en) begin got = 1'b1; break; end
      end
      if (!got) begin
        fail_event("read_timeout", k, k_n);
        run = 1'b0;
        break;
      end
      chk(k == 0 ? "start_latency" : "step_period", t, k == 0 ? 1 : PERIOD);
      chk("busy_running", busy, 1);
      if (k == k_n - 1) run = 1'b0;
      else if (k == flip_at) dir = ~dir;
    end
    run = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (!busy) begin got = 1'b1; break; end
    end
    chk("busy_fall", busy, 0);
    chk("reads_outstanding", sb_q.size(), 0);
    sb_q.delete();
  endtask

  // Monitor: pops the scoreboard on each RAM read and checks wrap and LED timing every cycle.
  initial begin : monitor
    exp_t              it;
    int                pend;
    logic [DATA_W-1:0] pend_v;
    logic [DATA_W-1:0] prev;
    logic              wexp;
    pend = 0; pend_v = '0; prev = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pend = 0;
        prev = leds;
        continue;
      end
      if (pend == 1) chk("leds_update", leds, pend_v);
      else           chk("leds_hold", leds, prev);
      if (pend > 0) pend--;
      wexp = 1'b0;
      if (rom_if.en) begin
        if (sb_q.size() == 0) begin
          fail_event("unexpected_read", int'(rom_if.addr), -1);
        end else begin
          it = sb_q.pop_front();
          chk("rom_addr", rom_if.addr, it.addr);
          wexp   = it.wrap;
          pend   = 2;
          pend_v = it.addr[DATA_W-1:0];
        end
      end
      chk("wrap", wrap, wexp);
      prev = leds;
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    int b, l, r, k_n;
    rst_n = 1'b0; run = 1'b0; dir = 1'b0; base_addr = '0; last_addr = '0;
    #3;
    chk("rst_leds", leds, 0);
    chk("rst_rom_en", rom_if.en, 0);
    chk("rst_rom_addr", rom_if.addr, 0);
    chk("rst_wrap", wrap, 0);
    chk("rst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_segment(2, 5, 1'b0, 5, -1, 1'b0);       // 2,3,4,5,2
    run_segment(2, 5, 1'b1, 5, -1, 1'b0);       // 5,4,3,2,5
    run_segment(2, 5, 1'b0, 6, 2, 1'b0);        // reverse mid-run
    run_segment(7, 7, 1'b0, 4, -1, 1'b0);       // single-word window
    run_segment(9, 3, 1'b1, 4, 1, 1'b0);        // inverted window pins at lo
    run_segment(4094, 4095, 1'b0, 4, -1, 1'b0); // wrap at top of address space
    run_segment(0, 4095, 1'b1, 3, 0, 1'b0);     // full window, wrap by compare

    // Reset during CAPTURE, then restart from base on release.
    sb_q.delete();
    plan(3, 8, 1'b0, 1, -1);
    @(negedge clk);
    base_addr = 12'd3; last_addr = 12'd8; dir = 1'b0; run = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (rom_if.en) break;
    end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_leds", leds, 0);
    chk("midrst_rom_en", rom_if.en, 0);
    chk("midrst_rom_addr", rom_if.addr, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_wrap", wrap, 0);
    run = 1'b0;
    repeat (2) @(negedge clk);
    sb_q.delete();
    run_segment(3, 8, 1'b0, 3, -1, 1'b1);

    for (int s = 0; s < 10; s++) begin
      b = $urandom_range(0, 4095);
      r = $urandom_range(0, 9);
      if (r < 2) l = (b > 0) ? $urandom_range(0, b) : 0;
      else       l = (b + r - 2 > 4095) ? 4095 : b + r - 2;
      k_n = $urandom_range(2, 8);
      run_segment(b, l, 1'($urandom_range(0, 1)), k_n, $urandom_range(0, k_n), 1'b0);
      repeat ($urandom_range(1, 4)) @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
